// File: rtl/debug_print_pkg.sv
// rtl/debug_print_pkg.sv - FSM state encoding and default sizes for the debug print arbiter
package debug_print_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } dp_state_e;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set bit of full above rr_ptr, wrapping
module rr_pick
    import debug_print_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDXW = $clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] full,
    input  logic [IDXW-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    always_comb begin
        int pos;
        pos   = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Walk the offsets farthest-first so the nearest full slot is the last one written.
        for (int k = NREQ; k >= 1; k--) begin
            pos = (int'(rr_ptr) + k) % NREQ;
            if (full[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = IDXW'(pos);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_print_arbiter.sv
// rtl/debug_print_arbiter.sv - round-robin share of one hex-dump UART printer among NREQ requesters
// Optional WAIT_BUSY abandon timer: define DEBUG_PRINT_ARBITER_TIMEOUT_EN.
module debug_print_arbiter
    import debug_print_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int IDXW    = 2,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ*32-1:0]   req_value,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          out_value,
    output logic                 out_value_good,
    input  logic                 out_ready,
    output logic [IDXW-1:0]      out_src,
    output logic                 busy,
    output logic                 err_timeout
);

    dp_state_e       state, state_nxt;
    logic [NREQ-1:0] full, cand, grant;
    logic [31:0]     hold [NREQ];
    logic [IDXW-1:0] rr_ptr, pick_idx;
    logic            pick_any, take, expired;

    rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
        .full   (full),
        .rr_ptr (rr_ptr),
        .grant  (cand),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign take      = (state == ST_IDLE) && out_ready && pick_any;
    assign grant     = take ? cand : '0;
    assign req_ready = ~full | grant;
    assign busy      = (|full) || (state != ST_IDLE);

    // A slot granted while its requester offers again reloads and stays full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full <= '0;
            for (int i = 0; i < NREQ; i++) hold[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    hold[i] <= req_value[32*i +: 32];
                    full[i] <= 1'b1;
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

`ifdef DEBUG_PRINT_ARBITER_TIMEOUT_EN
    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt;

    assign expired = (state == ST_WAIT_BUSY) && out_ready && (tcnt == T_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt        <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (state != ST_WAIT_BUSY) tcnt <= '0;
            else if (out_ready)        tcnt <= tcnt + 1'b1;
            if (expired) err_timeout <= 1'b1;
        end
    end
`else
    assign expired     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (take) state_nxt = ST_ISSUE;
            ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (!out_ready)   state_nxt = ST_WAIT_DONE;
                else if (expired) state_nxt = ST_IDLE;
            end
            ST_WAIT_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            rr_ptr         <= IDXW'(NREQ - 1);
            out_value      <= '0;
            out_src        <= '0;
            out_value_good <= 1'b0;
        end else begin
            state          <= state_nxt;
            out_value_good <= take;
            if (take) begin
                out_value <= hold[pick_idx];
                out_src   <= pick_idx;
                rr_ptr    <= pick_idx;
            end
        end
    end

endmodule

// File: tb/tb_debug_print_arbiter.sv
// tb/tb_debug_print_arbiter.sv - self-checking bench for debug_print_arbiter with a printer model
module tb_debug_print_arbiter;
    localparam int NREQ        = 4;
    localparam int IDXW        = 2;
    localparam int TIMEOUT     = 8;
    localparam int SAMPLECLOCK = 4;

    logic                clk       = 1'b0;
    logic                reset_n   = 1'b0;
    logic [NREQ*32-1:0]  req_value = '0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [31:0]         out_value;
    logic                out_value_good;
    logic                out_ready = 1'b1;
    logic [IDXW-1:0]     out_src;
    logic                busy;
    logic                err_timeout;

    always #5 clk = ~clk;

    debug_print_arbiter #(.NREQ(NREQ), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_value      (req_value),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .out_value      (out_value),
        .out_value_good (out_value_good),
        .out_ready      (out_ready),
        .out_src        (out_src),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-requester word lists, presented back-to-back
    logic [31:0]     txbuf [NREQ][16];
    int              tx_wr [NREQ];
    int              tx_rd [NREQ];
    logic [NREQ-1:0] acc = '0;

    task automatic push(input int i, input logic [31:0] v);
        txbuf[i][tx_wr[i]] = v;
        tx_wr[i]++;
    endtask

    function automatic bit drained();
        for (int i = 0; i < NREQ; i++) if (tx_rd[i] != tx_wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && acc[i]) tx_rd[i]++;
            if (tx_rd[i] < tx_wr[i]) begin
                req_valid[i]           = 1'b1;
                req_value[32*i +: 32]  = txbuf[i][tx_rd[i]];
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Printer: pm=0 prints 10 characters at SAMPLECLOCK cycles each; pm=1 holds ready stuck high
    int          pm     = 0;
    int          pr_cnt = 0;
    logic [79:0] pr_bits = '0;

    function automatic logic [79:0] hex_line(input logic [31:0] v);
        logic [79:0] r;
        logic [3:0]  d;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            d = v[31-4*k -: 4];
            r[79-8*k -: 8] = (d < 4'd10) ? 8'h30 + {4'h0, d} : 8'h37 + {4'h0, d};
        end
        r[15:0] = 16'h0D0A;
        return r;
    endfunction

    always @(posedge clk) begin
        #2;
        if (pm == 1) begin
            out_ready = 1'b1;
        end else if (pr_cnt > 0) begin
            pr_cnt--;
            if (pr_cnt == 0) out_ready = 1'b1;
        end else if (out_value_good && out_ready) begin
            pr_bits   = hex_line(out_value);
            pr_cnt    = 10 * SAMPLECLOCK;
            out_ready = 1'b0;
        end
    end

    // Behavioural model: slots, last winner, and whether the arbiter is free to grant
    logic [NREQ-1:0] m_full;
    logic [31:0]     m_val [NREQ];
    int              m_ptr, m_tcnt, m_out_src, win;
    bit              m_free, m_skip, m_low, m_strobe, m_err, m_take;
    logic [31:0]     m_out_val;
    logic [NREQ-1:0] exp_rdy;
    int              strobes = 0;
    bit              saw_reload = 0, saw_stall = 0;
    logic [31:0]     log_val [$];
    int              log_src [$];

    task automatic model_reset();
        m_full    = '0;
        for (int i = 0; i < NREQ; i++) m_val[i] = '0;
        m_ptr     = NREQ - 1;
        m_free    = 1;
        m_skip    = 0;
        m_low     = 0;
        m_strobe  = 0;
        m_err     = 0;
        m_tcnt    = 0;
        m_out_val = '0;
        m_out_src = 0;
    endtask

    always @(negedge clk) begin
        if (!reset_n) model_reset();
        m_take = 0;
        win    = 0;
        if (m_free && out_ready)
            for (int k = 1; k <= NREQ; k++)
                if (!m_take && m_full[(m_ptr + k) % NREQ]) begin
                    m_take = 1;
                    win    = (m_ptr + k) % NREQ;
                end
        exp_rdy = ~m_full;
        if (m_take) exp_rdy[win] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("out_value_good", out_value_good, m_strobe);
        check("out_value", out_value, m_out_val);
        check("out_src", out_src, m_out_src);
        check("busy", busy, (|m_full) || !m_free);
        check("err_timeout", err_timeout, m_err);
        if (out_value_good === 1'b1) begin
            strobes++;
            log_val.push_back(out_value);
            log_src.push_back(int'(out_src));
        end
        if (req_valid[2] && req_ready[2] && m_full[2]) saw_reload = 1;
        if (req_valid[2] && !req_ready[2]) saw_stall = 1;
        acc = reset_n ? req_ready : '0;
        if (reset_n) begin
            m_strobe = 0;
            if (m_take) begin
                m_out_val   = m_val[win];
                m_out_src   = win;
                m_ptr       = win;
                m_full[win] = 1'b0;
                m_free      = 0;
                m_skip      = 1;
                m_low       = 0;
                m_tcnt      = 0;
                m_strobe    = 1;
            end else if (!m_free) begin
                if (m_skip) m_skip = 0;
                else if (!m_low) begin
                    if (!out_ready) m_low = 1;
`ifdef DEBUG_PRINT_ARBITER_TIMEOUT_EN
                    else begin
                        m_tcnt++;
                        if (m_tcnt == TIMEOUT) begin
                            m_free = 1;
                            m_err  = 1;
                        end
                    end
`endif
                end else if (out_ready) m_free = 1;
            end
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && exp_rdy[i]) begin
                    m_full[i] = 1'b1;
                    m_val[i]  = req_value[32*i +: 32];
                end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        #1;
        while (!(!busy && out_ready && drained()) && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: arbiter never returned to idle within 2000 cycles", name);
        end
    endtask

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!out_value_good && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no out_value_good strobe within 200 cycles", name);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int pos, n, s0, j;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_value", out_value, 32'h0);
        check("rst_out_good", out_value_good, 1'b0);
        check("rst_out_src", out_src, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err_timeout, 1'b0);
        check("rst_req_ready", req_ready, 4'hF);
        @(negedge clk);
        #1 reset_n = 1'b1;

        // Single word from requester 0
        @(negedge clk);
        #2 push(0, 32'hDEADBEEF);
        wait_idle("t1_idle");
        check("t1_count", log_val.size(), 1);
        check("t1_value", log_val[0], 32'hDEADBEEF);
        check("t1_src", log_src[0], 0);
        check("t1_uart_line", pr_bits, "DEADBEEF\r\n");

        // Four slots loaded together, then reloaded: order 0..3 twice
        pulse_reset();
        log_val.delete();
        log_src.delete();
        #2;
        for (int i = 0; i < NREQ; i++) push(i, i);
        for (int i = 0; i < NREQ; i++) push(i, i + 4);
        wait_idle("t2_idle");
        check("t2_count", log_val.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t2_src", log_src[i], i % 4);
            check("t2_value", log_val[i], i);
        end

        // Requester 2 streams five words while requester 1 offers one
        @(negedge clk);
        log_val.delete();
        log_src.delete();
        #2;
        push(1, 32'h1000_0001);
        for (int i = 0; i < 5; i++) push(2, 32'h2000_0000 + i);
        wait_idle("t3_idle");
        check("t3_count", log_val.size(), 6);
        pos = 99;
        j   = 0;
        for (int i = 0; i < log_src.size(); i++) begin
            if (log_src[i] == 1 && pos == 99) pos = i;
            if (log_src[i] == 2) begin
                check("t3_req2_value", log_val[i], 32'h2000_0000 + j);
                j++;
            end
        end
        check("t3_req1_position_ok", pos <= 1, 1'b1);
        check("t3_req2_words", j, 5);
        check("t3_reload_on_grant", saw_reload, 1'b1);
        check("t3_stall_seen", saw_stall, 1'b1);

        // Reset while the printer is busy and two slots are full
        push(0, 32'hA0A0_0000);
        wait_strobe("t4_strobe");
        repeat (3) @(negedge clk);
        #2;
        push(1, 32'hB1B1_0001);
        push(3, 32'hB3B3_0003);
        n = 0;
        @(negedge clk);
        #1;
        while (!drained() && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t4_busy_before", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t4_good_in_reset", out_value_good, 1'b0);
        check("t4_busy_in_reset", busy, 1'b0);
        s0 = strobes;
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        check("t4_nothing_after_reset", strobes - s0, 0);

        // Printer ready stuck high
        pm = 1;
        @(negedge clk);
        #2;
        push(0, 32'h5555_0000);
        push(1, 32'h5555_0001);
        wait_strobe("t5_strobe");
        s0 = strobes;
`ifdef DEBUG_PRINT_ARBITER_TIMEOUT_EN
        n = 0;
        while (!err_timeout && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_timeout_delay", n, TIMEOUT + 1);
        wait_strobe("t5_second_strobe");
        check("t5_second_issue", strobes - s0, 1);
        check("t5_second_src", out_src, 1);
        wait_idle("t5_idle");
        pm = 0;
`else
        repeat (30) @(negedge clk);
        #1;
        check("t5_no_second_issue", strobes - s0, 0);
        check("t5_still_busy", busy, 1'b1);
        check("t5_no_err", err_timeout, 1'b0);
        pm = 0;
        pulse_reset();
`endif
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        n_bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/debug_print_arbiter.md
Name: debug_print_arbiter

Overview:
- Shares one hex-dump debug UART transmitter between NREQ requesters.
- The transmitter prints a 32-bit word as 8 ASCII hex digits followed by CR LF.
- Each requester gets a one-entry holding register with a valid/ready handshake.
- A round-robin scheduler issues one word at a time and sequences the transmitter's value_good/ready handshake. Sits between testbench/debug taps and the UART printer.

Parameters:
NREQ, 4, number of requesters (2..16)
IDXW, 2, requester index width; must equal clog2(NREQ)
TIMEOUT, 1023, cycles to wait in WAIT_BUSY before abandoning a word (used only with the optional feature)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, asynchronous, active-low
req_value  input  NREQ*32  requester words; requester i uses bits [32*i+31:32*i]
req_valid  input  NREQ  requester word offered
req_ready  output  NREQ  holding slot can accept; transfer occurs when valid&ready
out_value  output  32  word to printer
out_value_good  output  1  one-cycle issue strobe to printer
out_ready  input  1  printer idle (registered in printer; drops the cycle after a strobe)
out_src  output  IDXW  index of the requester owning out_value
busy  output  1  high if any slot is full or the FSM is not IDLE
err_timeout  output  1  sticky; set when a word is abandoned (0 without the optional feature)

Behaviour:
- Reset values: all slots empty; out_value=0; out_value_good=0; out_src=0; busy=0; err_timeout=0; FSM=IDLE; rr_ptr=NREQ-1, so requester 0 wins first.
- Slots:
  - req_ready[i] = ~full[i] | grant[i] (combinational).
  - On valid&ready, hold[i]<=req_value[i] and full[i]<=1.
  - Grant and capture in the same cycle: the slot reloads with the new word and stays full.
  - Full and not granted: req_ready[i]=0; the requester must hold its word.
- FSM: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if out_ready=1 and any full[i], pick the first full slot searching upward from rr_ptr+1 (modulo NREQ).
    - grant[i]=1 for that cycle; out_value<=hold[i], out_src<=i, rr_ptr<=i; full[i] cleared unless reloaded.
    - out_value_good<=1; go to ISSUE.
    - If out_ready=0, stay in IDLE; no grant.
  - ISSUE: out_value_good is high for exactly this cycle; it is 0 at the next edge. Go to WAIT_BUSY.
  - WAIT_BUSY: when out_ready=0, go to WAIT_DONE.
  - WAIT_DONE: when out_ready=1, go to IDLE.
- Throughput: at most one word per printer transaction, plus 3 cycles of arbiter overhead.
- Grant latency: a word in an empty slot with the FSM in IDLE and out_ready=1 is granted in the cycle after capture, and strobed 1 cycle later.
- out_value and out_src hold stable from the grant until the next grant.
- Fairness: a continuously full requester waits at most NREQ-1 other grants.
- Reset asserted mid-transfer:
  - All slots are flushed and out_value_good deasserts immediately (asynchronous).
  - The printer's in-flight character is not recalled.

Optional Feature:
DEBUG_PRINT_ARBITER_TIMEOUT_EN
- Defined:
  - A counter starts at 0 on entry to WAIT_BUSY.
  - If out_ready is still 1 after TIMEOUT cycles, set err_timeout (sticky until reset) and return to IDLE. The word is dropped.
  - The counter width is sized to hold TIMEOUT.
- Undefined:
  - No counter; WAIT_BUSY waits forever.
  - err_timeout is tied to 0.

Decomposition:
- Package debug_print_pkg holds:
  - the FSM state encodings (2-bit: IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3);
  - the default NREQ and TIMEOUT constants.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: full vector, rr_ptr.
  - Outputs: one-hot grant candidate, index, any.
  - Reused by later arbiters.

Test Plan:
- After reset, req0 offers 32'hDEADBEEF with an idle printer model (SAMPLECLOCK=4) -> one out_value_good pulse with out_value=DEADBEEF, out_src=0; UART line carries "DEADBEEF\r\n"; busy falls after the printer's ready returns.
- All four slots loaded in the same cycle with 0x0,0x1,0x2,0x3 -> print order 0,1,2,3. Reload all four -> order continues 0,1,2,3 (rr_ptr wraps from 3 to 0).
- req2 streams 5 words back-to-back while req1 offers one word -> req1's word is printed no later than second; req_ready[2] is low while slot 2 is full and the word is not yet granted.
- New valid on the same cycle as its slot's grant -> req_ready=1, the word is captured, and it is printed in a later transaction; no word is lost or duplicated.
- Reset pulsed during WAIT_DONE with two slots full -> out_value_good=0 and busy=0 immediately; nothing further is printed after release.
- With TIMEOUT_EN, TIMEOUT=8 and a printer model whose ready is stuck at 1 -> err_timeout rises 8 cycles after entering WAIT_BUSY, and the next pending word is issued. Without the macro -> FSM stays in WAIT_BUSY and err_timeout=0.
